seq_detect_multi: RTL
=====================

// Module: seq_detect_multi
// PURPOSE
//  Serial-bit sequence detector, multi-channel successor to the single-pattern N-bit detector.
//  Shifts one qualified serial bit per enabled clock into an N-bit history.
//  Compares it against K independent patterns, each with a don't-care mask, with
//  overlapping or non-overlapping detection. Sits on a serial data stream; flags feed control FSMs.
// PARAMETERS
//  N      8   pattern length in bits (N>=2)
//  K      4   number of pattern channels (K>=1)
//  CNT_W  16  width of per-channel match counters
// PORTS
//  clk        in   1        system clock, all state on posedge
//  reset      in   1        async, active-high; one clock; reset is asynchronous and active-high
//  en         in   1        serial bit qualifier; a sampled only when en=1
//  a          in   1        serial data bit
//  seq        in   [K][N]   patterns; seq[k][N-1] = oldest bit, seq[k][0] = newest bit
//  mask       in   [K][N]   1 = compare bit, 0 = don't care
//  overlap    in   1        1 = overlapping detection, 0 = non-overlapping
//  cnt_clr    in   1        synchronous clear of all match counters
//  valid      out  [K]      per-channel match flag, registered
//  any_valid  out  1        OR of valid, registered in same cycle as valid
//  match_cnt  out  [K][CNT_W] per-channel saturating match count
// BEHAVIOUR
//  - Reset values: sr=0, fill=0, gap[k]=0, valid=0, any_valid=0, match_cnt=0.
//  - Shift: on posedge with en=1, sr <= {sr[N-2:0], a}. With en=0, sr holds.
//  - fill counts shifted bits and saturates at N. History is full once N bits are in.
//  - Per-channel decision at an en=1 edge, using the post-shift history sr_nx:
//    hit[k] = full_nx && (((sr_nx ^ seq[k]) & mask[k]) == 0) && armed[k].
//    valid[k] <= hit[k]. Latency: valid is high in the cycle after the edge that sampled the final bit.
//  - At an en=0 edge: valid <= 0. Each valid is a one-cycle pulse per qualifying bit.
//  - armed[k]: always 1 when overlap=1. When overlap=0, armed[k] = (gap_nx[k] >= N).
//  - gap[k]: counts en bits since channel k's last hit and saturates at N.
//    Set to 0 on hit; otherwise +1 per en bit. It runs in both modes, so a mode switch takes effect at the next edge without glitches.
//  - Fully masked channel (mask=0): hits every bit after fill (overlap) or every N bits (non-overlap).
//  - seq, mask and overlap are sampled live each en edge. A change affects the next decision only; no flush, history kept.
//  - match_cnt[k]: +1 on each hit and saturates at 2^CNT_W-1.
//    cnt_clr has priority: clr and hit in the same edge -> 0. cnt_clr does not touch sr, fill or valid.
//  - Reset mid-stream: all state clears immediately (async). A full N new bits are needed before any valid.
// CONFIGURATION
//  SEQ_MATCH_CNT_EN defined: match_cnt counters are implemented as above.
//  SEQ_MATCH_CNT_EN undefined: no counter flops; match_cnt tied to 0; cnt_clr ignored. Ports are unchanged.
// STRUCTURE
//  seq_detect_pkg: default N/K/CNT_W localparams and gap/fill counter width function ($clog2(N+1)).
//  Sub-module seq_match_lane: compare, mask, gap, armed, valid flop and counter for one channel.
//  The lane is generated K times; shift register and fill counter are shared in the top.
// TESTING (bench uses N=4, K=2, CNT_W=4, reset held 3 clocks)
//  1. Fill: seq0=0000, mask0=1111, overlap=1, a=0, en=1.
//     -> valid[0]=0 after edges 1-3; =1 after edge 4 and every edge after; any_valid follows.
//  2. Overlap: seq0=1010, stream 1,0,1,0,1,0.
//     -> overlap=1: valid[0] after bits 4 and 6. overlap=0: only after bit 4.
//  3. Mask: seq1=1001, mask1=1001. Stream 1,1,0,1 -> valid[1]=1. Stream 1,1,0,0 -> valid[1]=0.
//  4. en gaps: 1010 with 2 idle cycles between bits.
//     -> valid 0 during idles; single pulse after the 4th en edge.
//  5. Counter: 20 hits -> match_cnt[0]=15 (saturated). cnt_clr with a hit on the same edge -> 0.
//     With the macro undefined -> always 0.
//  6. Reset after 3 bits of 1010: outputs 0 at once.
//     Following 0,1,0 gives no hit; a full 1,0,1,0 is needed -> valid[0].

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the multi-pattern serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_K     = 4;
  localparam int unsigned DEF_CNT_W = 16;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned ctr_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_match_lane.sv
// One detection channel: masked compare, overlap gap tracking, valid flop and match counter.
// Match counter present only when SEQ_MATCH_CNT_EN is defined.
module seq_match_lane
  import seq_detect_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             full_nx,
  input  logic [N-1:0]     sr_nx,
  input  logic [N-1:0]     seq,
  input  logic [N-1:0]     mask,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             hit,
  output logic             valid,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned GW = ctr_width(N);

  logic [GW-1:0] gap;
  logic [GW-1:0] gap_inc;
  logic          armed;
  logic          pat_ok;

  always_comb begin
    gap_inc = (gap >= GW'(N)) ? GW'(N) : gap + 1'b1;
    armed   = overlap || (gap_inc >= GW'(N));
    pat_ok  = ((sr_nx ^ seq) & mask) == '0;
    hit     = en && full_nx && pat_ok && armed;
  end

  // gap advances in both modes so an overlap switch needs no resync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= hit;
      if (en) gap <= hit ? '0 : gap_inc;
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (hit && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-channel serial sequence detector: shared history/fill, K generated match lanes.
// Optional per-channel match counters via SEQ_MATCH_CNT_EN.
module seq_detect_multi
  import seq_detect_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      a,
  input  logic [K-1:0][N-1:0]       seq,
  input  logic [K-1:0][N-1:0]       mask,
  input  logic                      overlap,
  input  logic                      cnt_clr,
  output logic [K-1:0]              valid,
  output logic                      any_valid,
  output logic [K-1:0][CNT_W-1:0]   match_cnt
);

  localparam int unsigned FW = ctr_width(N);

  logic [N-1:0]  sr;
  logic [N-1:0]  sr_nx;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_nx;
  logic          full_nx;
  logic [K-1:0]  hit;

  always_comb begin
    sr_nx   = {sr[N-2:0], a};
    fill_nx = (en && (fill != FW'(N))) ? fill + 1'b1 : fill;
    full_nx = (fill_nx == FW'(N));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      fill      <= '0;
      any_valid <= 1'b0;
    end else begin
      if (en) sr <= sr_nx;
      fill      <= fill_nx;
      any_valid <= |hit;
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_lane
    seq_match_lane #(
      .N     (N),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .full_nx   (full_nx),
      .sr_nx     (sr_nx),
      .seq       (seq[k]),
      .mask      (mask[k]),
      .overlap   (overlap),
      .cnt_clr   (cnt_clr),
      .hit       (hit[k]),
      .valid     (valid[k]),
      .match_cnt (match_cnt[k])
    );
  end

endmodule
